load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 170 +++++++++++++++++
 tb/tb_load_store_unit.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: IDLE/READ/WRITE/RESP sequencer between a core request port and a byte-addressed memory.
// Optional macro LSU_MISALIGN_TRAP_EN turns misaligned halfword/word accesses into errors.
module load_store_unit #(
    parameter int ADDR_LIMIT = 1024
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t state;
    state_t next_state;

    logic        write_q;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        err_q;
    logic [31:0] rdata_q;

    logic [2:0]  access_bytes;
    logic [32:0] end_addr;
    logic        misaligned;
    logic        req_error;
    logic        accept;
    logic [31:0] load_data;

    always_comb begin
        case (req_size)
            2'b00:   access_bytes = 3'd1;
            2'b01:   access_bytes = 3'd2;
            default: access_bytes = 3'd4;
        endcase
    end

    // Computed in 33 bits so an address near 2^32 cannot wrap below the limit.
    assign end_addr = {1'b0, req_addr} + {30'b0, access_bytes};

`ifdef LSU_MISALIGN_TRAP_EN
    assign misaligned = ((req_size == 2'b01) && req_addr[0]) ||
                        ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    assign req_error = (req_size == 2'b11) || (end_addr > 33'(ADDR_LIMIT)) || misaligned;
    assign accept    = req_valid && (state == IDLE);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            write_q    <= 1'b0;
            size_q     <= 2'b00;
            unsigned_q <= 1'b0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            err_q      <= 1'b0;
            rdata_q    <= 32'h0;
        end else begin
            if (accept) begin
                write_q    <= req_write;
                size_q     <= req_size;
                unsigned_q <= req_unsigned;
                addr_q     <= req_addr;
                wdata_q    <= req_wdata;
                err_q      <= req_error;
            end
            if (state == READ) begin
                rdata_q <= mem_rdata;
            end
        end
    end

    always_comb begin
        case (size_q)
            2'b00:   load_data = unsigned_q ? {24'h0, rdata_q[7:0]}
                                            : {{24{rdata_q[7]}}, rdata_q[7:0]};
            2'b01:   load_data = unsigned_q ? {16'h0, rdata_q[15:0]}
                                            : {{16{rdata_q[15]}}, rdata_q[15:0]};
            default: load_data = rdata_q;
        endcase
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_error) begin
                        next_state = RESP;
                    end else if (!req_write || (req_size != 2'b10)) begin
                        next_state = READ;
                    end else begin
                        next_state = WRITE;
                    end
                end
            end
            READ:    next_state = write_q ? WRITE : RESP;
            WRITE:   next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_rdata = 32'h0;
        rsp_err   = 1'b0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        case (state)
            IDLE: req_ready = 1'b1;
            READ: begin
                mem_re   = 1'b1;
                mem_addr = addr_q;
            end
            WRITE: begin
                // Gated by resetn so a reset edge landing in WRITE cannot commit the store.
                mem_we   = resetn;
                mem_addr = addr_q;
                case (size_q)
                    2'b00:   mem_wdata = {rdata_q[31:8], wdata_q[7:0]};
                    2'b01:   mem_wdata = {rdata_q[31:16], wdata_q[15:0]};
                    default: mem_wdata = wdata_q;
                endcase
            end
            RESP: begin
                rsp_valid = 1'b1;
                rsp_err   = err_q;
                if (!err_q && !write_q) begin
                    rsp_rdata = load_data;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: vector table driven through a response scoreboard,
// plus hand sequences for reset and abort behaviour, against a byte-array memory model.
module tb_load_store_unit;

    logic        clk;
    logic        resetn;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_rdata;

    load_store_unit #(.ADDR_LIMIT(1024)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_we       (mem_we),
        .mem_re       (mem_re),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        write;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        logic        chk_wdata;
        logic [31:0] exp_wdata;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          accept_cycle;
    } exp_t;

    vec_t        vecs[$];
    exp_t        sbq[$];
    int          checks;
    int          failures;
    int          cycle;
    int          mem_access;
    logic [31:0] last_wdata;
    logic [7:0]  mem [0:1026];

    // Byte-addressed memory: combinational little-endian read, 4-byte write on the next edge.
    always_comb begin
        mem_rdata = 32'h0;
        if (mem_addr < 32'd1024) begin
            mem_rdata = {mem[int'(mem_addr) + 3], mem[int'(mem_addr) + 2],
                         mem[int'(mem_addr) + 1], mem[int'(mem_addr)]};
        end
    end

    always @(posedge clk) begin
        cycle <= cycle + 1;
        if (mem_we && (mem_addr < 32'd1024)) begin
            mem[int'(mem_addr)]     <= mem_wdata[7:0];
            mem[int'(mem_addr) + 1] <= mem_wdata[15:8];
            mem[int'(mem_addr) + 2] <= mem_wdata[23:16];
            mem[int'(mem_addr) + 3] <= mem_wdata[31:24];
        end
    end

    task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        checkEq({e.name, " rdata"}, rsp_rdata, e.rdata);
        checkEq({e.name, " err"}, 32'(rsp_err), 32'(e.err));
        checkEq({e.name, " latency"}, 32'(cycle - e.accept_cycle + 1), 32'(e.lat));
        checkEq({e.name, " ready_in_resp"}, 32'(req_ready), 32'd0);
    endtask

    // Response monitor: pops the scoreboard on every rsp_valid and polices idle outputs.
    always @(negedge clk) begin
        if (mem_we || mem_re) begin
            mem_access++;
        end
        if (mem_we) begin
            last_wdata = mem_wdata;
        end
        if (resetn && !mem_we && !mem_re) begin
            checkEq("mem_idle_addr", mem_addr, 32'h0);
            checkEq("mem_idle_wdata", mem_wdata, 32'h0);
        end
        if (rsp_valid) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_rsp: got rsp_valid=1, expected 0 at cycle %0d", cycle);
            end else begin
                checkOutput(sbq.pop_front());
            end
        end else if (resetn) begin
            checkEq("rdata_when_no_rsp", rsp_rdata, 32'h0);
            checkEq("err_when_no_rsp", 32'(rsp_err), 32'd0);
        end
    end

    task automatic applyStimulus(input vec_t v);
        exp_t e;
        bit   seen_ready;
        @(negedge clk);
        req_valid    = 1'b1;
        req_write    = v.write;
        req_size     = v.size;
        req_unsigned = v.uns;
        req_addr     = v.addr;
        req_wdata    = v.wdata;
        mem_access   = 0;
        last_wdata   = 32'h0;
        seen_ready   = 1'b0;
        for (int i = 0; i < 10 && !seen_ready; i++) begin
            if (req_ready) begin
                seen_ready = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        if (!seen_ready) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s accept_timeout: got req_ready=0, expected 1", v.name);
            req_valid = 1'b0;
            return;
        end
        e.name         = v.name;
        e.rdata        = v.exp_rdata;
        e.err          = v.exp_err;
        e.lat          = v.exp_lat;
        e.accept_cycle = cycle + 1;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int i = 0; i < 10 && sbq.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (sbq.size() != 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s rsp_timeout: got no rsp_valid, expected one within 10 cycles", v.name);
            sbq.delete();
        end
        if (v.exp_err) begin
            checkEq({v.name, " mem_access_on_err"}, 32'(mem_access), 32'd0);
        end
        if (v.chk_wdata) begin
            checkEq({v.name, " mem_wdata"}, last_wdata, v.exp_wdata);
        end
    endtask

    function automatic vec_t mv(input string name, input logic wr, input logic [1:0] sz,
                                input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                                input logic [31:0] rd, input logic err, input int lat,
                                input logic chk, input logic [31:0] ewd);
        vec_t v;
        v.name = name; v.write = wr; v.size = sz; v.uns = uns; v.addr = addr; v.wdata = wd;
        v.exp_rdata = rd; v.exp_err = err; v.exp_lat = lat; v.chk_wdata = chk; v.exp_wdata = ewd;
        return v;
    endfunction

    initial begin
        checks       = 0;
        failures     = 0;
        cycle        = 0;
        mem_access   = 0;
        last_wdata   = 32'h0;
        resetn       = 1'b0;
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
        for (int i = 0; i < 1027; i++) mem[i] = 8'h00;
        mem[0] = 8'h05;

        //  name               wr  size  uns  addr          wdata          exp_rdata      err  lat chk  exp_wdata
        vecs.push_back(mv("ld_w_0",      0, 2'b10, 0, 32'd0,    32'h0,        32'h00000005, 0, 2, 0, 32'h0));
        vecs.push_back(mv("st_b_0",      1, 2'b00, 0, 32'd0,    32'hFFFFFFAB, 32'h0,        0, 3, 1, 32'h000000AB));
        vecs.push_back(mv("ld_b_s_0",    0, 2'b00, 0, 32'd0,    32'h0,        32'hFFFFFFAB, 0, 2, 0, 32'h0));
        vecs.push_back(mv("ld_b_u_0",    0, 2'b00, 1, 32'd0,    32'h0,        32'h000000AB, 0, 2, 0, 32'h0));
        vecs.push_back(mv("st_w_8",      1, 2'b10, 0, 32'd8,    32'h12345678, 32'h0,        0, 2, 1, 32'h12345678));
        vecs.push_back(mv("st_h_8",      1, 2'b01, 0, 32'd8,    32'h0000BEEF, 32'h0,        0, 3, 1, 32'h1234BEEF));
        vecs.push_back(mv("ld_w_8",      0, 2'b10, 0, 32'd8,    32'h0,        32'h1234BEEF, 0, 2, 0, 32'h0));
        vecs.push_back(mv("ld_h_s_8",    0, 2'b01, 0, 32'd8,    32'h0,        32'hFFFFBEEF, 0, 2, 0, 32'h0));
        vecs.push_back(mv("ld_h_u_8",    0, 2'b01, 1, 32'd8,    32'h0,        32'h0000BEEF, 0, 2, 0, 32'h0));
        vecs.push_back(mv("ld_w_1022",   0, 2'b10, 0, 32'd1022, 32'h0,        32'h0,        1, 1, 0, 32'h0));
        vecs.push_back(mv("ld_size11",   0, 2'b11, 0, 32'd0,    32'h0,        32'h0,        1, 1, 0, 32'h0));
        vecs.push_back(mv("st_size11",   1, 2'b11, 0, 32'd0,    32'h1,        32'h0,        1, 1, 0, 32'h0));
        vecs.push_back(mv("st_w_1021",   1, 2'b10, 0, 32'd1021, 32'h1,        32'h0,        1, 1, 0, 32'h0));
        vecs.push_back(mv("ld_w_huge",   0, 2'b10, 0, 32'hFFFFFFFC, 32'h0,    32'h0,        1, 1, 0, 32'h0));
        vecs.push_back(mv("st_w_1020",   1, 2'b10, 0, 32'd1020, 32'h8899AABB, 32'h0,        0, 2, 1, 32'h8899AABB));
        vecs.push_back(mv("ld_b_s_1023", 0, 2'b00, 0, 32'd1023, 32'h0,        32'hFFFFFF88, 0, 2, 0, 32'h0));
        vecs.push_back(mv("ld_h_u_1022", 0, 2'b01, 1, 32'd1022, 32'h0,        32'h00008899, 0, 2, 0, 32'h0));
        vecs.push_back(mv("st_w_0",      1, 2'b10, 0, 32'd0,    32'h11223344, 32'h0,        0, 2, 1, 32'h11223344));
        vecs.push_back(mv("st_w_4",      1, 2'b10, 0, 32'd4,    32'h55667788, 32'h0,        0, 2, 1, 32'h55667788));
`ifdef LSU_MISALIGN_TRAP_EN
        vecs.push_back(mv("ld_w_2_mis",  0, 2'b10, 0, 32'd2,    32'h0,        32'h0,        1, 1, 0, 32'h0));
        vecs.push_back(mv("ld_h_1_mis",  0, 2'b01, 0, 32'd1,    32'h0,        32'h0,        1, 1, 0, 32'h0));
`else
        vecs.push_back(mv("ld_w_2_mis",  0, 2'b10, 0, 32'd2,    32'h0,        32'h77881122, 0, 2, 0, 32'h0));
        vecs.push_back(mv("ld_h_1_mis",  0, 2'b01, 0, 32'd1,    32'h0,        32'h00002233, 0, 2, 0, 32'h0));
`endif
        vecs.push_back(mv("ld_b_s_3",    0, 2'b00, 0, 32'd3,    32'h0,        32'h00000011, 0, 2, 0, 32'h0));

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkEq("reset_req_ready", 32'(req_ready), 32'd1);
        checkEq("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        checkEq("reset_rsp_rdata", rsp_rdata, 32'h0);
        checkEq("reset_mem_we", 32'(mem_we), 32'd0);
        checkEq("reset_mem_re", 32'(mem_re), 32'd0);
        checkEq("reset_mem_addr", mem_addr, 32'h0);
        resetn = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
        end

        // Reset landing while a word store is in WRITE: store must not reach memory.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'd16; req_wdata = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        checkEq("abort_w_in_write", 32'(mem_we), 32'd1);
        checkEq("abort_w_busy", 32'(req_ready), 32'd0);
        resetn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkEq("abort_w_ready", 32'(req_ready), 32'd1);
        checkEq("abort_w_no_we", 32'(mem_we), 32'd0);
        checkEq("abort_w_mem", {mem[19], mem[18], mem[17], mem[16]}, 32'h0);
        resetn = 1'b1;
        repeat (3) @(negedge clk);

        // Reset landing while a byte store is in READ.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00;
        req_addr = 32'd20; req_wdata = 32'h00000077;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        checkEq("abort_b_in_read", 32'(mem_re), 32'd1);
        resetn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkEq("abort_b_ready", 32'(req_ready), 32'd1);
        resetn = 1'b1;
        repeat (3) @(negedge clk);

        applyStimulus(mv("ld_w_16_after_abort", 0, 2'b10, 0, 32'd16, 32'h0, 32'h0, 0, 2, 0, 32'h0));
        applyStimulus(mv("ld_b_u_20_after_abort", 0, 2'b00, 1, 32'd20, 32'h0, 32'h0, 0, 2, 0, 32'h0));

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got no completion, expected finish before 200000");
        $fatal(1);
    end

endmodule
